// File: rtl/dice_router_cfg_sequencer.sv
// dice_router_cfg_sequencer
// Multi-context configuration store and context switcher for the 2x32 CGRA
// tile router. A config stream fills one of NUM_CTX slots track by track, and
// a dispatcher switches the registered active copy that drives the router.
// Optional feature macro: DICE_RCFG_PARITY_EN (per-beat even parity check).
module dice_router_cfg_sequencer #(
  parameter int NUM_TRACKS = 12,
  parameter int SEL_W      = 4,
  parameter int NUM_CTX    = 4,
  localparam int CTX_W     = $clog2(NUM_CTX),
  localparam int CFG_W     = SEL_W + 2,
  localparam int CNT_W     = $clog2(NUM_TRACKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic [CTX_W-1:0]            cfg_ctx,
  output logic                        cfg_idle,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CFG_W-1:0]            cfg_data,
  input  logic                        cfg_par,
  output logic                        cfg_done,
  output logic                        cfg_err,
  input  logic                        sw_req,
  input  logic [CTX_W-1:0]            sw_ctx,
  output logic                        sw_ack,
  output logic                        sw_err,
  output logic [NUM_TRACKS*SEL_W-1:0] sel_o,
  output logic [NUM_TRACKS-1:0]       ovl_en_o,
  output logic [NUM_TRACKS-1:0]       reg_mode_o,
  output logic [CTX_W-1:0]            active_ctx_o,
  output logic [NUM_CTX-1:0]          ctx_valid_o
);

  typedef enum logic {IDLE, LOAD} state_t;

  // Track word layout: {registered_mode, overload_en, sel}.
  // 4'hF is an unused select code, so the router drives 0 out of reset.
  localparam logic [CFG_W-1:0] TRK_RST = {2'b00, {SEL_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_TRACKS - 1);

  state_t                             state;
  logic [CTX_W-1:0]                   ctx_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic [NUM_CTX-1:0]                 ctx_valid_q;
  logic [CTX_W-1:0]                   active_q;
  logic [NUM_TRACKS-1:0][CFG_W-1:0]   slot_mem [NUM_CTX];
  logic [NUM_TRACKS-1:0][CFG_W-1:0]   act_q;
  logic                               beat_acc;
  logic                               beat_bad;
  logic                               beat_wr;

`ifdef DICE_RCFG_PARITY_EN
  // Even parity over data plus parity bit; any odd count rejects the beat.
  assign beat_bad = ^{cfg_data, cfg_par};
`else
  logic unused_par;
  assign unused_par = cfg_par;
  assign beat_bad   = 1'b0;
`endif

  assign beat_acc  = (state == LOAD) && cfg_valid;
  assign beat_wr   = beat_acc && !beat_bad;
  assign cfg_idle  = (state == IDLE);
  assign cfg_ready = (state == LOAD);

  // Slot storage is deliberately not reset; only the valid flags gate its use.
  always_ff @(posedge clk) begin
    if (beat_wr) slot_mem[ctx_q][cnt_q] <= cfg_data;
  end

  // Load FSM: start latches the target slot, beats fill tracks in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ctx_q       <= '0;
      cnt_q       <= '0;
      ctx_valid_q <= '0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state                <= LOAD;
            ctx_q                <= cfg_ctx;
            cnt_q                <= '0;
            ctx_valid_q[cfg_ctx] <= 1'b0;
          end
        end
        LOAD: begin
          if (beat_acc) begin
            if (beat_bad) begin
              // Abort: slot stays invalid, partial contents are harmless.
              state   <= IDLE;
              cfg_err <= 1'b1;
            end else if (cnt_q == LAST) begin
              state              <= IDLE;
              ctx_valid_q[ctx_q] <= 1'b1;
              cfg_done           <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Context switch: copy a valid slot into the active registers one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q    <= {NUM_TRACKS{TRK_RST}};
      active_q <= '0;
      sw_ack   <= 1'b0;
      sw_err   <= 1'b0;
    end else begin
      sw_ack <= 1'b0;
      sw_err <= 1'b0;
      if (sw_req) begin
        // A slot under load has its flag clear, so a same-cycle write never
        // races with this read.
        if (ctx_valid_q[sw_ctx]) begin
          act_q    <= slot_mem[sw_ctx];
          active_q <= sw_ctx;
          sw_ack   <= 1'b1;
        end else begin
          sw_err   <= 1'b1;
        end
      end
    end
  end

  // Fan the active copy out to the router's per-track fields.
  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
    assign sel_o[t*SEL_W +: SEL_W] = act_q[t][SEL_W-1:0];
    assign ovl_en_o[t]             = act_q[t][SEL_W];
    assign reg_mode_o[t]           = act_q[t][SEL_W+1];
  end

  assign active_ctx_o = active_q;
  assign ctx_valid_o  = ctx_valid_q;

endmodule

// File: tb/tb_dice_router_cfg_sequencer.sv
// tb_dice_router_cfg_sequencer
// Scoreboard bench: switch and load outcomes are predicted from a small
// context model when stimulus is driven and compared when the DUT pulses.
module tb_dice_router_cfg_sequencer;

  localparam int NT = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [1:0]  cfg_ctx;
  logic        cfg_idle;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [5:0]  cfg_data;
  logic        cfg_par;
  logic        cfg_done;
  logic        cfg_err;
  logic        sw_req;
  logic [1:0]  sw_ctx;
  logic        sw_ack;
  logic        sw_err;
  logic [47:0] sel_o;
  logic [11:0] ovl_en_o;
  logic [11:0] reg_mode_o;
  logic [1:0]  active_ctx_o;
  logic [3:0]  ctx_valid_o;

  dice_router_cfg_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_ctx(cfg_ctx), .cfg_idle(cfg_idle),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_par(cfg_par), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .sw_req(sw_req), .sw_ctx(sw_ctx), .sw_ack(sw_ack), .sw_err(sw_err),
    .sel_o(sel_o), .ovl_en_o(ovl_en_o), .reg_mode_o(reg_mode_o),
    .active_ctx_o(active_ctx_o), .ctx_valid_o(ctx_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        err;
    logic [47:0] sel;
    logic [11:0] ovl;
    logic [11:0] mode;
    logic [1:0]  ctx;
    int          due;
  } sw_exp_t;

  typedef struct {
    logic done;
    logic err;
  } ld_exp_t;

  sw_exp_t sw_q[$];
  ld_exp_t ld_q[$];

  int n_chk  = 0;
  int n_err  = 0;
  int n_done = 0;
  int cyc    = 0;

  // Reference model of slot contents, flags and the active copy.
  logic [5:0] m_mem [4][NT];
  logic [5:0] m_act [NT];
  logic [1:0] m_active;
  logic [3:0] m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [47:0] p_sel();
    logic [47:0] v;
    for (int i = 0; i < NT; i++) v[i*4 +: 4] = m_act[i][3:0];
    return v;
  endfunction

  function automatic logic [11:0] p_ovl();
    logic [11:0] v;
    for (int i = 0; i < NT; i++) v[i] = m_act[i][4];
    return v;
  endfunction

  function automatic logic [11:0] p_mode();
    logic [11:0] v;
    for (int i = 0; i < NT; i++) v[i] = m_act[i][5];
    return v;
  endfunction

  function automatic logic [5:0] beat(input int set, input int i);
    logic [3:0] t;
    t = 4'(i);
    case (set)
      0:       return {1'b1, 1'b0, t};
      1:       return {1'b0, 1'b1, 4'(15 - i)};
      default: return {t[0], ~t[0], 4'(i + 3)};
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NT; i++) m_act[i] = 6'h0F;
    m_active = 2'd0;
    m_valid  = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a switch request for the coming edge and predict its outcome.
  task automatic sw_drive(input int c);
    sw_exp_t e;
    sw_req = 1'b1;
    sw_ctx = 2'(c);
    if (m_valid[c]) begin
      e.ack = 1'b1; e.err = 1'b0;
      for (int i = 0; i < NT; i++) m_act[i] = m_mem[c][i];
      m_active = 2'(c);
    end else begin
      e.ack = 1'b0; e.err = 1'b1;
    end
    e.sel  = p_sel();
    e.ovl  = p_ovl();
    e.mode = p_mode();
    e.ctx  = m_active;
    e.due  = cyc + 1;
    sw_q.push_back(e);
  endtask

  task automatic do_switch(input int c);
    sw_drive(c);
    tick();
    sw_req = 1'b0;
  endtask

  // mid: 1 = switch to ctx0 plus stray cfg_start before beat 4,
  //      2 = checks plus refused switch to ctx0 before beat 4,
  //      3 = switch to the loading slot on the final beat.
  task automatic do_load(input int c, input int set, input int bad_idx,
                         input int mid, input int abort_at);
    ld_exp_t le;
    bit      fail_par;
    fail_par = 1'b0;
`ifdef DICE_RCFG_PARITY_EN
    fail_par = (bad_idx >= 0);
`endif
    if (abort_at < 0) begin
      le.done = !fail_par;
      le.err  = fail_par;
      ld_q.push_back(le);
    end
    cfg_start = 1'b1;
    cfg_ctx   = 2'(c);
    tick();
    cfg_start = 1'b0;
    m_valid[c] = 1'b0;
    chk("load_idle", cfg_idle, 0);
    chk("load_ready", cfg_ready, 1);
    for (int i = 0; i < NT; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        return;
      end
      if (i == 3 && mid == 1) begin
        cfg_start = 1'b1;
        cfg_ctx   = 2'd1;
        sw_drive(0);
        tick();
        cfg_start = 1'b0;
        sw_req    = 1'b0;
        cfg_ctx   = 2'(c);
      end
      if (i == 3 && mid == 2) begin
        chk("reload_valid0", ctx_valid_o[0], 0);
        chk("reload_hold_sel", sel_o, p_sel());
        sw_drive(0);
        tick();
        sw_req = 1'b0;
      end
      cfg_valid = 1'b1;
      cfg_data  = beat(set, i);
      cfg_par   = (^beat(set, i)) ^ (i == bad_idx);
      if (mid == 3 && i == NT - 1) sw_drive(c);
      tick();
      cfg_valid = 1'b0;
      sw_req    = 1'b0;
      if (fail_par && i == bad_idx) return;
      m_mem[c][i] = beat(set, i);
    end
    m_valid[c] = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop a prediction whenever the DUT reports an outcome.
  always @(negedge clk) begin
    sw_exp_t se;
    ld_exp_t le;
    if (sw_ack || sw_err) begin
      if (sw_q.size() == 0) begin
        chk("sw_unexpected", 1, 0);
      end else begin
        se = sw_q.pop_front();
        chk("sw_ack", sw_ack, se.ack);
        chk("sw_err", sw_err, se.err);
        chk("sw_cycle", cyc, se.due);
        chk("sw_sel", sel_o, se.sel);
        chk("sw_ovl", ovl_en_o, se.ovl);
        chk("sw_mode", reg_mode_o, se.mode);
        chk("sw_active", active_ctx_o, se.ctx);
      end
    end
    if (cfg_done) n_done++;
    if (cfg_done || cfg_err) begin
      if (ld_q.size() == 0) begin
        chk("ld_unexpected", 1, 0);
      end else begin
        le = ld_q.pop_front();
        chk("ld_done", cfg_done, le.done);
        chk("ld_err", cfg_err, le.err);
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_ctx = 2'd0; cfg_valid = 1'b0;
    cfg_data = 6'd0; cfg_par = 1'b0; sw_req = 1'b0; sw_ctx = 2'd0;
    m_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_sel", sel_o, 48'hFFFF_FFFF_FFFF);
    chk("rst_ovl", ovl_en_o, 0);
    chk("rst_mode", reg_mode_o, 0);
    chk("rst_valid", ctx_valid_o, 0);
    chk("rst_idle", cfg_idle, 1);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_active", active_ctx_o, 0);
    chk("rst_pulses", {cfg_done, cfg_err, sw_ack, sw_err}, 0);

    // Basic load of ctx2 and switch to it.
    do_load(2, 0, -1, 0, -1);
    tick();
    chk("valid_c2", ctx_valid_o, 4'b0100);
    chk("done_count", n_done, 1);
    chk("idle_after_load", cfg_idle, 1);
    do_switch(2);
    chk("sel_ramp", sel_o, 48'hBA98_7654_3210);
    chk("mode_fff", reg_mode_o, 12'hFFF);
    chk("ovl_zero", ovl_en_o, 0);

    // Never-loaded slot is refused.
    do_switch(1);
    chk("err_hold_sel", sel_o, 48'hBA98_7654_3210);

    // Load ctx0, switch to it, then re-switch to the already-active slot.
    do_load(0, 1, -1, 0, -1);
    do_switch(0);
    do_switch(0);

    // Switch to ctx2 on its own final reload beat is refused, then accepted.
    do_load(2, 0, -1, 3, -1);
    do_switch(2);

    // ctx3 load with a switch to ctx0 and an ignored cfg_start mid-load.
    do_load(3, 1, -1, 1, -1);
    tick();
    chk("valid_after_c3", ctx_valid_o, m_valid);
    chk("active_c0", active_ctx_o, 0);

    // Reload the active ctx0: outputs hold the old copy until switched again.
    do_load(0, 2, -1, 2, -1);
    tick();
    chk("hold_after_reload", sel_o, p_sel());
    do_switch(0);
    chk("new_c0_ovl", ovl_en_o, p_ovl());

    // Bad parity on beat 7 of a ctx1 load.
    do_load(1, 0, 6, 0, -1);
    tick();
    chk("par_valid1", ctx_valid_o[1], m_valid[1]);
    chk("par_idle", cfg_idle, 1);

    // Reset in the middle of a ctx3 load.
    do_load(3, 2, -1, 0, 4);
    chk("abort_idle", cfg_idle, 1);
    chk("abort_valid", ctx_valid_o, 0);
    chk("abort_sel", sel_o, 48'hFFFF_FFFF_FFFF);
    chk("abort_active", active_ctx_o, 0);

    repeat (4) tick();
    chk("sw_q_left", sw_q.size(), 0);
    chk("ld_q_left", ld_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
